// File: rtl/bus_master_arbiter.sv
// N-way arbiter that takes the 68000 bus via BR/BG/BGACK and hands it to internal masters.
// Grant 1 edge after synced BG/AS/BGACK allow; masters wait on req; forced release after hold_limit cycles.
module bus_master_arbiter #(
  parameter int N           = 4,
  parameter int HOLD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MCLK,
  input  logic              SRES,
  input  logic [N-1:0]      req,
  input  logic              mode_rr,
  input  logic              chain,
  input  logic [HOLD_W-1:0] hold_limit,
  input  logic              BG,
  input  logic              AS,
  input  logic              BGACK_i,
  output logic [N-1:0]      gnt,
  output logic              BR_pull,
  output logic              BGACK_pull,
  output logic              busy,
  output logic              preempt
);

  localparam int PW = $clog2(N);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_BUS, OWN, RELEASE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] bg_sync, as_sync, bgack_sync;
  logic                   bg_s, as_s, bgack_s;
  logic [PW-1:0]          ptr, winner;
  logic [HOLD_W-1:0]      cnt;
  logic [N-1:0]           others;
  logic [PW-1:0]          new_win, oth_win;
  logic                   win_req, limit_hit;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // Round-robin scans upward from start with wrap; fixed priority scans from index 0.
  function automatic logic [PW-1:0] pick(input logic [N-1:0] r, input logic [PW-1:0] start,
                                          input logic rr);
    logic [PW-1:0] win;
    logic          found;
    int            j;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = rr ? (int'(start) + i) % N : i;
      if (!found && r[j]) begin
        win   = PW'(j);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      bg_sync    <= '1;
      as_sync    <= '1;
      bgack_sync <= '1;
    end else begin
      bg_sync    <= (bg_sync << 1) | SYNC_STAGES'(BG);
      as_sync    <= (as_sync << 1) | SYNC_STAGES'(AS);
      bgack_sync <= (bgack_sync << 1) | SYNC_STAGES'(BGACK_i);
    end
  end

  assign bg_s    = bg_sync[SYNC_STAGES-1];
  assign as_s    = as_sync[SYNC_STAGES-1];
  assign bgack_s = bgack_sync[SYNC_STAGES-1];

  assign others    = req & ~(N'(1) << winner);
  assign new_win   = pick(req, ptr, mode_rr);
  assign oth_win   = pick(others, ptr, mode_rr);
  assign win_req   = req[winner];
  assign limit_hit = (hold_limit != '0) && (cnt == hold_limit);
  assign busy      = (state != IDLE);

  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state      <= IDLE;
      gnt        <= '0;
      BR_pull    <= 1'b0;
      BGACK_pull <= 1'b0;
      preempt    <= 1'b0;
      ptr        <= '0;
      winner     <= '0;
      cnt        <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) state <= REQ;
        end
        REQ: begin
          if (!(|req)) begin
            state   <= IDLE;
            BR_pull <= 1'b0;
          end else begin
            BR_pull <= 1'b1;
            if (!bg_s) state <= WAIT_BUS;
          end
        end
        WAIT_BUS: begin
          if (!(|req)) begin
            state   <= IDLE;
            BR_pull <= 1'b0;
          end else if (as_s && bgack_s) begin
            state      <= OWN;
            winner     <= new_win;
            gnt        <= N'(1) << new_win;
            BGACK_pull <= 1'b1;
            BR_pull    <= 1'b0;
            cnt        <= HOLD_W'(1);
            ptr        <= next_idx(new_win);
          end else begin
            BR_pull <= 1'b1;
          end
        end
        OWN: begin
          // A voluntary drop wins over a coincident limit hit, so no preempt pulse then.
          if (!win_req) begin
            state <= RELEASE;
            gnt   <= '0;
          end else if (limit_hit) begin
            state   <= RELEASE;
            gnt     <= '0;
            preempt <= 1'b1;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (chain && (|others)) begin
            state  <= OWN;
            winner <= oth_win;
            gnt    <= N'(1) << oth_win;
            cnt    <= HOLD_W'(1);
            ptr    <= next_idx(oth_win);
          end else begin
            BGACK_pull <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: vector table, directed handshake sequences, randomized run vs rule model.
module tb_bus_master_arbiter;
  localparam int N = 4;
  localparam int HOLD_W = 8;

  logic              MCLK = 1'b0;
  logic              SRES = 1'b0;
  logic [N-1:0]      req = '0;
  logic              mode_rr = 1'b0, chain = 1'b0;
  logic [HOLD_W-1:0] hold_limit = '0;
  logic              BG = 1'b1, AS = 1'b1, BGACK_i = 1'b1;
  logic [N-1:0]      gnt;
  logic              BR_pull, BGACK_pull, busy, preempt;

  int n_cmp = 0;
  int n_bad = 0;
  bit cpu_auto = 1'b1;
  bit foreign = 1'b0;

  // reference model state for the randomized run
  int owner, len, mptr, rel_owner, grants;
  bit in_rel;
  logic [N-1:0] g_prev;

  typedef struct {
    bit       rr;
    logic [3:0] rq;
    logic [3:0] ga;
    logic [3:0] gb;
  } vec_t;
  vec_t tbl[8];

  typedef struct {
    bit rr;
    bit ch;
    int lim;
  } seg_t;
  seg_t segs[5];

  always #5 MCLK = ~MCLK;

  bus_master_arbiter #(.N(N), .HOLD_W(HOLD_W), .SYNC_STAGES(2)) dut (
    .MCLK(MCLK), .SRES(SRES), .req(req), .mode_rr(mode_rr), .chain(chain),
    .hold_limit(hold_limit), .BG(BG), .AS(AS), .BGACK_i(BGACK_i), .gnt(gnt),
    .BR_pull(BR_pull), .BGACK_pull(BGACK_pull), .busy(busy), .preempt(preempt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock; the CPU side reacts just after the edge, outputs are sampled on the falling edge.
  task automatic step();
    @(posedge MCLK);
    #1;
    if (cpu_auto) begin
      BG      = ~BR_pull;
      BGACK_i = ~(BGACK_pull | foreign);
    end
    @(negedge MCLK);
  endtask

  task automatic do_reset();
    SRES = 1'b0;
    req = '0; mode_rr = 1'b0; chain = 1'b0; hold_limit = '0;
    BG = 1'b1; AS = 1'b1; BGACK_i = 1'b1; foreign = 1'b0; cpu_auto = 1'b1;
    repeat (2) @(negedge MCLK);
    SRES = 1'b1;
    @(negedge MCLK);
  endtask

  task automatic wait_gnt(input string name, input int limit);
    int c;
    c = 0;
    while (gnt == '0 && c < limit) begin
      step();
      c++;
    end
    if (gnt == '0) check({name, "_timeout"}, 32'(c), 32'(limit + 1));
  endtask

  function automatic int exp_win(logic [3:0] r, int p, bit rr, int excl);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = rr ? (p + k) % N : k;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(int e);
    logic [3:0] v;
    v = '0;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_seq[21];
    logic [3:0] req_e;
    int errs, pcnt, e, c;
    bit cont;

    tbl[0] = '{1'b0, 4'b1010, 4'b0010, 4'b1000};
    tbl[1] = '{1'b0, 4'b1111, 4'b0001, 4'b0010};
    tbl[2] = '{1'b1, 4'b1111, 4'b0001, 4'b0010};
    tbl[3] = '{1'b1, 4'b1001, 4'b0001, 4'b1000};
    tbl[4] = '{1'b0, 4'b1001, 4'b0001, 4'b1000};
    tbl[5] = '{1'b0, 4'b0100, 4'b0100, 4'b0000};
    tbl[6] = '{1'b1, 4'b0110, 4'b0010, 4'b0100};
    tbl[7] = '{1'b1, 4'b1010, 4'b0010, 4'b1000};

    segs[0] = '{1'b0, 1'b0, 5};
    segs[1] = '{1'b1, 1'b1, 3};
    segs[2] = '{1'b1, 1'b0, 0};
    segs[3] = '{1'b0, 1'b1, 2};
    segs[4] = '{1'b1, 1'b1, 1};

    // reset values
    do_reset();
    check("reset_outputs", 32'({gnt, BR_pull, BGACK_pull, busy, preempt}), 32'(0));

    // table: first grant, forced release after 3 cycles, chained second grant
    for (int i = 0; i < 8; i++) begin
      do_reset();
      mode_rr = tbl[i].rr; chain = 1'b1; hold_limit = 8'd3; req = tbl[i].rq;
      wait_gnt("tbl_first", 40);
      check("tbl_first_gnt", 32'(gnt), 32'(tbl[i].ga));
      check("tbl_first_pins", 32'({BR_pull, BGACK_pull}), 32'(2'b01));
      repeat (3) step();
      check("tbl_preempt", 32'({gnt, preempt}), 32'({4'b0000, 1'b1}));
      step();
      check("tbl_second_gnt", 32'(gnt), 32'(tbl[i].gb));
    end

    // handshake timing with manual BG
    do_reset();
    cpu_auto = 1'b0; req = 4'b1010;
    step();
    check("br_edge1", 32'({busy, BR_pull}), 32'(2'b10));
    step();
    check("br_edge2", 32'(BR_pull), 32'(1));
    repeat (3) step();
    BG = 1'b0;
    repeat (3) step();
    check("bg_wait", 32'(gnt), 32'(0));
    step();
    check("bg_grant", 32'({gnt, BR_pull, BGACK_pull}), 32'({4'b0010, 1'b0, 1'b1}));
    req = '0;
    step();
    check("vol_gnt_fall", 32'({gnt, BGACK_pull}), 32'({4'b0000, 1'b1}));
    step();
    check("vol_bgack_fall", 32'({BGACK_pull, busy}), 32'(0));

    // unlimited hold for 300 cycles
    do_reset();
    req = 4'b0100;
    wait_gnt("long", 40);
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (gnt !== 4'b0100 || preempt !== 1'b0) errs++;
    end
    check("long_hold_errs", 32'(errs), 32'(0));
    req = '0;
    step();
    check("long_rel1", 32'({gnt, BGACK_pull}), 32'({4'b0000, 1'b1}));
    step();
    check("long_rel2", 32'(BGACK_pull), 32'(0));

    // round-robin chained rotation
    do_reset();
    mode_rr = 1'b1; chain = 1'b1; hold_limit = 8'd4; req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) exp_seq[g * 5 + k] = oh(g);
      exp_seq[g * 5 + 4] = 4'b0000;
    end
    exp_seq[20] = 4'b0001;
    wait_gnt("rr", 40);
    pcnt = 0;
    for (int k = 0; k < 21; k++) begin
      if (k > 0) step();
      check("rr_seq", 32'(gnt), 32'(exp_seq[k]));
      if (preempt) pcnt++;
    end
    check("rr_preempts", 32'(pcnt), 32'(4));

    // request withdrawn while still in REQ
    do_reset();
    cpu_auto = 1'b0; req = 4'b0001;
    step(); step();
    check("abort_br", 32'(BR_pull), 32'(1));
    req = '0;
    step();
    check("abort_idle", 32'({BR_pull, busy}), 32'(0));
    errs = 0;
    repeat (6) begin
      step();
      if (gnt !== '0) errs++;
    end
    check("abort_no_gnt", 32'(errs), 32'(0));

    // AS low blocks the grant
    do_reset();
    cpu_auto = 1'b0; AS = 1'b0; req = 4'b0010;
    repeat (2) step();
    BG = 1'b0;
    repeat (10) step();
    check("as_block", 32'(gnt), 32'(0));
    AS = 1'b1;
    repeat (2) step();
    check("as_sync", 32'(gnt), 32'(0));
    step();
    check("as_grant", 32'(gnt), 32'(4'b0010));

    // foreign BGACK blocks the grant
    do_reset();
    cpu_auto = 1'b0; BGACK_i = 1'b0; req = 4'b0010;
    repeat (2) step();
    BG = 1'b0;
    repeat (10) step();
    check("bgack_block", 32'(gnt), 32'(0));
    BGACK_i = 1'b1;
    repeat (2) step();
    check("bgack_sync", 32'(gnt), 32'(0));
    step();
    check("bgack_grant", 32'(gnt), 32'(4'b0010));

    // all-ones hold limit is reachable
    do_reset();
    hold_limit = 8'hFF; req = 4'b0001;
    wait_gnt("maxhold", 40);
    c = 0;
    pcnt = 0;
    while (gnt != '0 && c < 400) begin
      c++;
      step();
    end
    if (preempt) pcnt++;
    check("maxhold_len", 32'(c), 32'(255));
    check("maxhold_preempt", 32'(pcnt), 32'(1));

    // asynchronous reset mid-tenure, then restart with ptr back at 0
    do_reset();
    mode_rr = 1'b1; req = 4'b0100;
    wait_gnt("arst", 40);
    check("arst_gnt", 32'(gnt), 32'(4'b0100));
    req = 4'b1111;
    repeat (2) step();
    #2 SRES = 1'b0;
    #1 check("arst_async", 32'({gnt, BGACK_pull, BR_pull, busy}), 32'(0));
    @(negedge MCLK);
    SRES = 1'b1;
    wait_gnt("arst_restart", 60);
    check("arst_ptr0", 32'(gnt), 32'(4'b0001));

    // randomized traffic vs rule model
    do_reset();
    owner = -1; len = 0; mptr = 0; rel_owner = -1; grants = 0; in_rel = 1'b0; g_prev = '0;
    for (int s = 0; s < 5; s++) begin
      mode_rr = segs[s].rr; chain = segs[s].ch; hold_limit = HOLD_W'(segs[s].lim);
      for (int k = 0; k < 1200; k++) begin
        if (k < 1180) begin
          for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
        end else begin
          req = '0;
        end
        req_e = req;
        step();
        if (g_prev != '0 && owner >= 0) begin
          cont = req_e[owner] && !(segs[s].lim != 0 && len == segs[s].lim);
          if (cont) begin
            check("rand_hold", 32'({gnt, preempt}), 32'({g_prev, 1'b0}));
            len++;
          end else begin
            check("rand_release", 32'({gnt, preempt}), 32'({4'b0000, req_e[owner]}));
            in_rel = 1'b1;
            rel_owner = owner;
            owner = -1;
          end
        end else if (in_rel) begin
          in_rel = 1'b0;
          if (segs[s].ch && (req_e & ~oh(rel_owner)) != '0) begin
            e = exp_win(req_e, mptr, segs[s].rr, rel_owner);
            check("rand_chain", 32'({gnt, preempt}), 32'({oh(e), 1'b0}));
            owner = e; len = 1; mptr = (e + 1) % N; grants++;
          end else begin
            check("rand_idle", 32'({gnt, BGACK_pull, preempt}), 32'(0));
          end
        end else if (gnt != '0) begin
          e = exp_win(req_e, mptr, segs[s].rr, -1);
          check("rand_grant", 32'({gnt, BGACK_pull, BR_pull, preempt}),
                32'({oh(e), 1'b1, 1'b0, 1'b0}));
          owner = e; len = 1; mptr = (e + 1) % N; grants++;
        end
        g_prev = gnt;
      end
    end
    check("rand_activity", 32'(grants > 100), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
